// File: rtl/alu_pkg.sv
// Shared definitions for the instruction-decode stage that feeds the ALU.
// Holds the ALUctl op codes, the RV32I major opcodes and the decoded-bundle type.
package alu_pkg;

    localparam int XLEN = 32;

    // ALUctl operation codes understood by the combinational ALU
    localparam logic [4:0] ALU_AND   = 5'd0;
    localparam logic [4:0] ALU_OR    = 5'd1;
    localparam logic [4:0] ALU_ADD   = 5'd2;
    localparam logic [4:0] ALU_XOR   = 5'd3;
    localparam logic [4:0] ALU_SLL   = 5'd4;
    localparam logic [4:0] ALU_SRL   = 5'd5;
    localparam logic [4:0] ALU_SUB   = 5'd6;
    localparam logic [4:0] ALU_SLT   = 5'd7;
    localparam logic [4:0] ALU_SGE   = 5'd8;
    localparam logic [4:0] ALU_PASSA = 5'd9;
    localparam logic [4:0] ALU_PASSB = 5'd10;
    localparam logic [4:0] ALU_EQ    = 5'd11;
    localparam logic [4:0] ALU_NE    = 5'd12;
    localparam logic [4:0] ALU_SLTU  = 5'd13;
    localparam logic [4:0] ALU_SGEU  = 5'd14;
    localparam logic [4:0] ALU_SRA   = 5'd15;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [4:0]      alu_ctl;
        logic            a_sel;
        logic            b_sel;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            reg_write;
        logic            is_load;
        logic            is_store;
        logic            is_branch;
        logic            is_jump;
        logic            illegal;
    } dec_t;

    // Arithmetic/logic op for OP and OP-IMM; alt selects sub/sra encodings
    function automatic logic [4:0] arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_decode_comb.sv
// Purely combinational RV32I instruction -> decoded bundle translation.
// Unsupported encodings collapse to an all-zero bundle with only illegal set.
module alu_decode_comb
    import alu_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_t        dec_o
);

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic            f7_zero;
    logic            f7_alt;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc     = instr_i[6:0];
    assign f3      = instr_i[14:12];
    assign f7      = instr_i[31:25];
    assign f7_zero = (f7 == 7'b0000000);
    assign f7_alt  = (f7 == 7'b0100000);
    assign imm_i   = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s   = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b   = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u   = {instr_i[31:12], 12'b0};
    assign imm_j   = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    // Decode by major opcode, then squash illegal encodings and writes to x0
    always_comb begin
        logic legal;
        dec_o = '0;
        legal = 1'b1;
        case (opc)
            OPC_OP: begin
                legal          = f7_zero || (f7_alt && (f3 == 3'b000 || f3 == 3'b101));
                dec_o.alu_ctl  = arith_op(f3, f7_alt);
                dec_o.rs1      = instr_i[19:15];
                dec_o.rs2      = instr_i[24:20];
                dec_o.rd       = instr_i[11:7];
                dec_o.reg_write = 1'b1;
            end
            OPC_OPIMM: begin
                if (f3 == 3'b001) begin
                    legal = f7_zero;
                end else if (f3 == 3'b101) begin
                    legal = f7_zero || f7_alt;
                end
                // Shift amounts are zero-extended so the ALU can shift by all of B
                dec_o.alu_ctl  = arith_op(f3, (f3 == 3'b101) && f7_alt);
                dec_o.imm      = (f3 == 3'b001 || f3 == 3'b101) ? {27'b0, instr_i[24:20]} : imm_i;
                dec_o.b_sel    = 1'b1;
                dec_o.rs1      = instr_i[19:15];
                dec_o.rd       = instr_i[11:7];
                dec_o.reg_write = 1'b1;
            end
            OPC_LUI: begin
                dec_o.alu_ctl  = ALU_PASSB;
                dec_o.b_sel    = 1'b1;
                dec_o.imm      = imm_u;
                dec_o.rd       = instr_i[11:7];
                dec_o.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec_o.alu_ctl  = ALU_ADD;
                dec_o.a_sel    = 1'b1;
                dec_o.b_sel    = 1'b1;
                dec_o.imm      = imm_u;
                dec_o.rd       = instr_i[11:7];
                dec_o.reg_write = 1'b1;
            end
            OPC_BRANCH: begin
                case (f3)
                    3'b000:  dec_o.alu_ctl = ALU_EQ;
                    3'b001:  dec_o.alu_ctl = ALU_NE;
                    3'b100:  dec_o.alu_ctl = ALU_SLT;
                    3'b101:  dec_o.alu_ctl = ALU_SGE;
                    3'b110:  dec_o.alu_ctl = ALU_SLTU;
                    3'b111:  dec_o.alu_ctl = ALU_SGEU;
                    default: legal = 1'b0;
                endcase
                dec_o.imm       = imm_b;
                dec_o.rs1       = instr_i[19:15];
                dec_o.rs2       = instr_i[24:20];
                dec_o.is_branch = 1'b1;
            end
            OPC_LOAD: begin
                legal          = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                                 (f3 == 3'b100) || (f3 == 3'b101);
                dec_o.alu_ctl  = ALU_ADD;
                dec_o.b_sel    = 1'b1;
                dec_o.imm      = imm_i;
                dec_o.rs1      = instr_i[19:15];
                dec_o.rd       = instr_i[11:7];
                dec_o.reg_write = 1'b1;
                dec_o.is_load  = 1'b1;
            end
            OPC_STORE: begin
                legal          = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
                dec_o.alu_ctl  = ALU_ADD;
                dec_o.b_sel    = 1'b1;
                dec_o.imm      = imm_s;
                dec_o.rs1      = instr_i[19:15];
                dec_o.rs2      = instr_i[24:20];
                dec_o.is_store = 1'b1;
            end
            OPC_JAL: begin
                dec_o.alu_ctl  = ALU_ADD;
                dec_o.a_sel    = 1'b1;
                dec_o.b_sel    = 1'b1;
                dec_o.imm      = imm_j;
                dec_o.rd       = instr_i[11:7];
                dec_o.reg_write = 1'b1;
                dec_o.is_jump  = 1'b1;
            end
            OPC_JALR: begin
                legal          = (f3 == 3'b000);
                dec_o.alu_ctl  = ALU_ADD;
                dec_o.b_sel    = 1'b1;
                dec_o.imm      = imm_i;
                dec_o.rs1      = instr_i[19:15];
                dec_o.rd       = instr_i[11:7];
                dec_o.reg_write = 1'b1;
                dec_o.is_jump  = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec_o         = '0;
            dec_o.illegal = 1'b1;
        end
        if (dec_o.rd == 5'd0) begin
            dec_o.reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/alu_decode.sv
// Registered decode stage: valid/ready handshake on both sides around alu_decode_comb.
// Build option ALU_DECODE_SKID_EN selects a 2-entry skid buffer with a registered
// in_ready; otherwise a single output register with combinational in_ready.
module alu_decode
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      alu_ctl,
    output logic            a_sel,
    output logic            b_sel,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] pc,
    output logic            reg_write,
    output logic            is_load,
    output logic            is_store,
    output logic            is_branch,
    output logic            is_jump,
    output logic            illegal
);

    dec_t            dec;
    dec_t            m_bund_q, m_bund_d;
    logic [XLEN-1:0] m_pc_q, m_pc_d;
    logic            m_valid_q, m_valid_d;

    alu_decode_comb u_comb (
        .instr_i (in_instr),
        .dec_o   (dec)
    );

`ifdef ALU_DECODE_SKID_EN
    dec_t            s_bund_q, s_bund_d;
    logic [XLEN-1:0] s_pc_q, s_pc_d;
    logic            s_valid_q, s_valid_d;
    logic            rdy_q, rdy_d;
    logic            push, pop;

    assign in_ready = rdy_q;
    assign push     = in_valid && rdy_q;
    assign pop      = m_valid_q && out_ready;

    // Skid next-state: output entry refills from skid first, new words park in skid on stall
    always_comb begin
        m_valid_d = m_valid_q;
        m_bund_d  = m_bund_q;
        m_pc_d    = m_pc_q;
        s_valid_d = s_valid_q;
        s_bund_d  = s_bund_q;
        s_pc_d    = s_pc_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (s_valid_q) begin
            if (pop) begin
                m_bund_d  = s_bund_q;
                m_pc_d    = s_pc_q;
                s_valid_d = 1'b0;
            end
        end else if (!m_valid_q || pop) begin
            m_valid_d = push;
            if (push) begin
                m_bund_d = dec;
                m_pc_d   = in_pc;
            end
        end else if (push) begin
            s_valid_d = 1'b1;
            s_bund_d  = dec;
            s_pc_d    = in_pc;
        end
        rdy_d = !s_valid_d;
    end

    // Skid entry and registered ready; cleared asynchronously on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid_q <= 1'b0;
            s_bund_q  <= '0;
            s_pc_q    <= '0;
            rdy_q     <= 1'b1;
        end else begin
            s_valid_q <= s_valid_d;
            s_bund_q  <= s_bund_d;
            s_pc_q    <= s_pc_d;
            rdy_q     <= rdy_d;
        end
    end
`else
    assign in_ready = !m_valid_q || out_ready;

    // Single-entry next-state: load whenever the slot is free or being drained
    always_comb begin
        m_valid_d = m_valid_q;
        m_bund_d  = m_bund_q;
        m_pc_d    = m_pc_q;
        if (flush) begin
            m_valid_d = 1'b0;
        end else if (in_ready) begin
            m_valid_d = in_valid;
            if (in_valid) begin
                m_bund_d = dec;
                m_pc_d   = in_pc;
            end
        end
    end
`endif

    // Output entry; reset clears payload too so nothing partial is ever visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_bund_q  <= '0;
            m_pc_q    <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_bund_q  <= m_bund_d;
            m_pc_q    <= m_pc_d;
        end
    end

    assign out_valid = m_valid_q;
    assign alu_ctl   = m_bund_q.alu_ctl;
    assign a_sel     = m_bund_q.a_sel;
    assign b_sel     = m_bund_q.b_sel;
    assign imm       = m_bund_q.imm;
    assign rs1       = m_bund_q.rs1;
    assign rs2       = m_bund_q.rs2;
    assign rd        = m_bund_q.rd;
    assign pc        = m_pc_q;
    assign reg_write = m_bund_q.reg_write;
    assign is_load   = m_bund_q.is_load;
    assign is_store  = m_bund_q.is_store;
    assign is_branch = m_bund_q.is_branch;
    assign is_jump   = m_bund_q.is_jump;
    assign illegal   = m_bund_q.illegal;

endmodule
